// File: rtl/reg_write_arbiter_if.sv
// Bus between N register writers and the shared-register arbiter.
// Requesters sit on the master side; the arbiter and register sit on the slave side.
interface reg_write_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 2
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] I;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   O;
  logic               wr;
  logic               locked;
  logic [PW-1:0]      owner;

  modport master (
    output req, lock, I,
    input  gnt, O, wr, locked, owner
  );

  modport slave (
    input  req, lock, I,
    output gnt, O, wr, locked, owner
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter in front of one WIDTH-bit holding register shared by N writers.
// A winner may lock the register and keep writing exclusively until it drops lock.
module reg_write_arbiter #(
  parameter int unsigned      N     = 4,
  parameter int unsigned      WIDTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner_q;
  logic [WIDTH-1:0] o_q;
  logic             wr_q;
  logic             locked_q;

  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      scan;
  logic [N-1:0]     gnt_c;
  logic [WIDTH-1:0] wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] x);
    if (x == PW'(N - 1)) return '0;
    return x + PW'(1);
  endfunction

  // Winner selection: owner only while locked, otherwise first requester from ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    if (!RESET) begin
      if (state == ST_LOCKED) begin
        win_idx = owner_q;
        win_vld = bus.req[owner_q];
      end else begin
        for (int unsigned i = 0; i < N; i++) begin
          scan = {1'b0, ptr} + (PW+1)'(i);
          if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
          if (!win_vld && bus.req[scan[PW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan[PW-1:0];
          end
        end
      end
    end
  end

  // One-hot grant and the grant-driven data mux.
  always_comb begin
    gnt_c = '0;
    wdata = '0;
    if (win_vld) gnt_c[win_idx] = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_c[k]) wdata = wdata | bus.I[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_ARB;
      ptr      <= '0;
      owner_q  <= '0;
      o_q      <= INIT;
      wr_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      wr_q <= win_vld;
      if (win_vld) o_q <= wdata;
      case (state)
        ST_ARB: begin
          if (win_vld) begin
            owner_q <= win_idx;
            ptr     <= ptr_inc(win_idx);
            if (bus.lock[win_idx]) begin
              state    <= ST_LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          // Releasing lock still lets this cycle's write land.
          if (!bus.lock[owner_q]) begin
            state    <= ST_ARB;
            locked_q <= 1'b0;
            ptr      <= ptr_inc(owner_q);
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.O      = o_q;
  assign bus.wr     = wr_q;
  assign bus.locked = locked_q;
  assign bus.owner  = owner_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter with N=4, WIDTH=2, INIT=0: directed cycle table,
// then randomized cycles checked against a reference model.
module tb_reg_write_arbiter;
  logic CLK;
  logic RESET;

  reg_write_arbiter_if #(.N(4), .WIDTH(2)) bus ();

  reg_write_arbiter #(.N(4), .WIDTH(2), .INIT(2'd0)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] data;
    logic [3:0] gnt;
    logic [1:0] o;
    logic       wr;
    logic       lk;
    logic [1:0] own;
  } vec_t;

  typedef struct {
    logic [1:0] o;
    logic       wr;
    logic       lk;
    logic [1:0] own;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational grant, then check registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge CLK);
    RESET    = v.rst;
    bus.req  = v.req;
    bus.lock = v.lock;
    bus.I    = v.data;
    #1;
    chk($sformatf("gnt[%0d]", idx), 32'(bus.gnt), 32'(v.gnt));
    sb.push_back('{o: v.o, wr: v.wr, lk: v.lk, own: v.own});
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("O[%0d]", idx),      32'(bus.O),      32'(e.o));
      chk($sformatf("wr[%0d]", idx),     32'(bus.wr),     32'(e.wr));
      chk($sformatf("locked[%0d]", idx), 32'(bus.locked), 32'(e.lk));
      chk($sformatf("owner[%0d]", idx),  32'(bus.owner),  32'(e.own));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   m_ptr, m_own, w;
    logic m_lk;
    logic [1:0] m_o;
    vec_t v;

    RESET    = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.I    = '0;

    // I=8'hE4 -> k3..k0 = 3,2,1,0 ; I=8'h1B -> k3..k0 = 0,1,2,3
    //              rst   req      lock     data   gnt      O     wr    lk    own
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 8'hE4, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}); // reset
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0}); // round robin
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd3});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 8'h1B, 4'b0010, 2'd2, 1'b1, 1'b0, 2'd1}); // ptr -> 2
    vecs.push_back('{1'b0, 4'b0110, 4'b0100, 8'h1B, 4'b0100, 2'd1, 1'b1, 1'b1, 2'd2}); // lock by 2
    vecs.push_back('{1'b0, 4'b0110, 4'b0100, 8'hE4, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 4'b0110, 4'b0100, 8'h1B, 4'b0100, 2'd1, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 4'b0110, 4'b0100, 8'hE4, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 4'b0011, 4'b0100, 8'hE4, 4'b0000, 2'd2, 1'b0, 1'b1, 2'd2}); // locked idle
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 8'hE4, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd2}); // release, ptr 3
    vecs.push_back('{1'b0, 4'b0110, 4'b0000, 8'hE4, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1}); // winner 1
    vecs.push_back('{1'b0, 4'b0100, 4'b0000, 8'hE4, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2}); // ptr -> 3
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 8'hE4, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0}); // wrap/skip
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 8'hE4, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2});
    vecs.push_back('{1'b0, 4'b1001, 4'b0000, 8'hE4, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd3}); // winner 3 wraps
    vecs.push_back('{1'b0, 4'b1001, 4'b0000, 8'hE4, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 8'h1B, 4'b0010, 2'd2, 1'b1, 1'b1, 2'd1}); // lock by 1
    vecs.push_back('{1'b0, 4'b1011, 4'b0010, 8'hE4, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 8'h1B, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}); // reset mid-lock
    vecs.push_back('{1'b0, 4'b1010, 4'b0000, 8'hE4, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});
    vecs.push_back('{1'b0, 4'b0001, 4'b0001, 8'hE4, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0}); // lock by 0
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 8'h1B, 4'b0001, 2'd3, 1'b1, 1'b0, 2'd0}); // write + release
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'hE4, 4'b0000, 2'd3, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 8'hE4, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd1});

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Model state after the last table entry.
    m_ptr = 2; m_own = 1; m_lk = 1'b0; m_o = 2'd1;

    for (int c = 0; c < 300; c++) begin
      v.rst  = ($urandom_range(0, 31) == 0);
      v.req  = 4'($urandom_range(0, 15));
      v.lock = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if ($urandom_range(0, 3) == 0) v.lock = 4'h0;
      v.data = 8'($urandom);
      v.gnt  = 4'b0000;
      w = -1;
      if (!v.rst) begin
        if (m_lk) begin
          if (v.req[m_own]) w = m_own;
        end else begin
          for (int off = 0; off < 4; off++) begin
            if (w < 0 && v.req[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
          end
        end
      end
      if (w >= 0) v.gnt[w] = 1'b1;
      if (v.rst) begin
        m_o = 2'd0; m_ptr = 0; m_own = 0; m_lk = 1'b0; v.wr = 1'b0;
      end else begin
        v.wr = (w >= 0);
        if (w >= 0) m_o = 2'((v.data >> (2 * w)) & 8'h3);
        if (m_lk) begin
          if (!v.lock[m_own]) begin
            m_lk  = 1'b0;
            m_ptr = (m_own + 1) % 4;
          end
        end else if (w >= 0) begin
          m_own = w;
          m_ptr = (w + 1) % 4;
          if (v.lock[w]) m_lk = 1'b1;
        end
      end
      v.o   = m_o;
      v.lk  = m_lk;
      v.own = 2'(m_own);
      apply(v, 100 + c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
